// File: rtl/div_issue_ctrl_pkg.sv
// Shared types and constants for the divider issue controller and its result cache.
package div_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    DIV_  = 2'd0,
    DIVU_ = 2'd1,
    REM_  = 2'd2,
    REMU_ = 2'd3
  } div_ops_e;

  typedef enum logic {
    FREE = 1'b0,
    BUSY = 1'b1
  } fu_state_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    CAP_Q = 3'd2,
    CAP_R = 3'd3,
    RESP  = 3'd4
  } div_ctrl_state_e;

  // Enabled divider cycles from operand load to result hold.
  localparam int DIV_CYCLES_DEF = 34;

  function automatic logic op_is_signed(input div_ops_e op);
    return (op == DIV_) || (op == REM_);
  endfunction

  function automatic logic op_is_div(input div_ops_e op);
    return (op == DIV_) || (op == DIVU_);
  endfunction

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Request/response handshake bundle between the issue stage and the divider controller.
interface div_issue_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
);
  logic                         req_valid_i;
  logic                         req_ready_o;
  div_issue_ctrl_pkg::div_ops_e req_op_i;
  logic [XLEN-1:0]              req_dividend_i;
  logic [XLEN-1:0]              req_divisor_i;
  logic [TAG_W-1:0]             req_tag_i;

  logic                         resp_valid_o;
  logic                         resp_ready_i;
  logic [XLEN-1:0]              resp_result_o;
  logic [TAG_W-1:0]             resp_tag_o;
  logic                         resp_zero_div_o;

  modport master (
    output req_valid_i, req_op_i, req_dividend_i, req_divisor_i, req_tag_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_result_o, resp_tag_o, resp_zero_div_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_dividend_i, req_divisor_i, req_tag_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_result_o, resp_tag_o, resp_zero_div_o
  );
endinterface

// File: rtl/div_result_cache.sv
// Single-entry cache of the last completed division: operands, signedness, quotient and remainder.
module div_result_cache #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_dividend,
  input  logic [XLEN-1:0] wr_divisor,
  input  logic            wr_signed,
  input  logic [XLEN-1:0] wr_q,
  input  logic [XLEN-1:0] wr_r,
  input  logic [XLEN-1:0] lk_dividend,
  input  logic [XLEN-1:0] lk_divisor,
  input  logic            lk_signed,
  output logic            hit,
  output logic [XLEN-1:0] q,
  output logic [XLEN-1:0] r
);

  logic            valid_reg;
  logic [XLEN-1:0] dividend_reg;
  logic [XLEN-1:0] divisor_reg;
  logic            signed_reg;
  logic [XLEN-1:0] q_reg;
  logic [XLEN-1:0] r_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_reg    <= 1'b0;
      dividend_reg <= '0;
      divisor_reg  <= '0;
      signed_reg   <= 1'b0;
      q_reg        <= '0;
      r_reg        <= '0;
    end else if (wr_en) begin
      valid_reg    <= 1'b1;
      dividend_reg <= wr_dividend;
      divisor_reg  <= wr_divisor;
      signed_reg   <= wr_signed;
      q_reg        <= wr_q;
      r_reg        <= wr_r;
    end
  end

  assign hit = valid_reg && (dividend_reg == lk_dividend) &&
               (divisor_reg == lk_divisor) && (signed_reg == lk_signed);
  assign q   = q_reg;
  assign r   = r_reg;

endmodule

// File: rtl/div_issue_ctrl.sv
// Front-end for the iterative divider: special-case and cache short-cuts, divider sequencing,
// quotient/remainder capture and tagged result return.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int TAG_W      = 4,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  div_issue_ctrl_if.slave        bus,
  input  logic                   flush_i,
  output fu_state_e              fu_state_o,
  output logic [XLEN-1:0]        div_dividend_o,
  output logic [XLEN-1:0]        div_divisor_o,
  output div_ops_e               div_op_o,
  output logic                   div_clk_en_o,
  output logic                   div_rst_n_o,
  input  logic [XLEN-1:0]        div_result_i
);

  localparam int              CNT_W    = $clog2(DIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  div_ctrl_state_e  state_reg, state_next;
  logic [CNT_W-1:0] counter_reg, counter_next;
  div_ops_e         op_reg, op_next;
  logic [XLEN-1:0]  dividend_reg, dividend_next;
  logic [XLEN-1:0]  divisor_reg, divisor_next;
  logic [TAG_W-1:0] tag_reg, tag_next;
  logic [XLEN-1:0]  q_capt_reg, q_capt_next;
  logic             req_ready_reg, req_ready_next;
  logic             resp_valid_reg, resp_valid_next;
  logic [XLEN-1:0]  resp_result_reg, resp_result_next;
  logic [TAG_W-1:0] resp_tag_reg, resp_tag_next;
  logic             resp_zero_div_reg, resp_zero_div_next;
  logic             div_clk_en_reg, div_clk_en_next;
  div_ops_e         div_op_reg, div_op_next;
  logic             div_rst_n_reg;

  logic             req_fire;
  logic             cache_wr;
  logic             cache_hit;
  logic [XLEN-1:0]  cache_q;
  logic [XLEN-1:0]  cache_r;

  div_result_cache #(.XLEN(XLEN)) u_cache (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .wr_en       (cache_wr),
    .wr_dividend (dividend_reg),
    .wr_divisor  (divisor_reg),
    .wr_signed   (op_is_signed(op_reg)),
    .wr_q        (q_capt_reg),
    .wr_r        (div_result_i),
    .lk_dividend (bus.req_dividend_i),
    .lk_divisor  (bus.req_divisor_i),
    .lk_signed   (op_is_signed(bus.req_op_i)),
    .hit         (cache_hit),
    .q           (cache_q),
    .r           (cache_r)
  );

  always_comb begin
    state_next         = state_reg;
    counter_next       = counter_reg;
    op_next            = op_reg;
    dividend_next      = dividend_reg;
    divisor_next       = divisor_reg;
    tag_next           = tag_reg;
    q_capt_next        = q_capt_reg;
    resp_valid_next    = resp_valid_reg;
    resp_result_next   = resp_result_reg;
    resp_tag_next      = resp_tag_reg;
    resp_zero_div_next = resp_zero_div_reg;
    cache_wr           = 1'b0;
    req_fire           = bus.req_valid_i && req_ready_reg && !flush_i;

    case (state_reg)
      IDLE: begin
        if (req_fire) begin
          op_next            = bus.req_op_i;
          dividend_next      = bus.req_dividend_i;
          divisor_next       = bus.req_divisor_i;
          tag_next           = bus.req_tag_i;
          resp_tag_next      = bus.req_tag_i;
          resp_zero_div_next = 1'b0;
          if (bus.req_divisor_i == '0) begin
            resp_result_next   = op_is_div(bus.req_op_i) ? '1 : bus.req_dividend_i;
            resp_zero_div_next = 1'b1;
            resp_valid_next    = 1'b1;
            state_next         = RESP;
          end else if (op_is_signed(bus.req_op_i) && (bus.req_dividend_i == INT_MIN) &&
                       (bus.req_divisor_i == '1)) begin
            resp_result_next = op_is_div(bus.req_op_i) ? INT_MIN : '0;
            resp_valid_next  = 1'b1;
            state_next       = RESP;
          end else if (cache_hit) begin
            resp_result_next = op_is_div(bus.req_op_i) ? cache_q : cache_r;
            resp_valid_next  = 1'b1;
            state_next       = RESP;
          end else begin
            counter_next = '0;
            state_next   = RUN;
          end
        end
      end
      RUN: begin
        counter_next = counter_reg + 1'b1;
        if (counter_reg == CNT_LAST) state_next = CAP_Q;
      end
      CAP_Q: begin
        q_capt_next = div_result_i;
        state_next  = CAP_R;
      end
      CAP_R: begin
        cache_wr           = 1'b1;
        resp_result_next   = op_is_div(op_reg) ? q_capt_reg : div_result_i;
        resp_tag_next      = tag_reg;
        resp_zero_div_next = 1'b0;
        resp_valid_next    = 1'b1;
        state_next         = RESP;
      end
      RESP: begin
        if (bus.resp_ready_i) begin
          resp_valid_next = 1'b0;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // A flush abandons everything in flight; a capture cut short must not reach the cache.
    if (flush_i) begin
      state_next      = IDLE;
      resp_valid_next = 1'b0;
      cache_wr        = 1'b0;
    end

    req_ready_next  = (state_next == IDLE);
    div_clk_en_next = (state_next == RUN);
    case (state_next)
      RUN:     div_op_next = op_next;
      CAP_Q:   div_op_next = op_is_signed(op_next) ? DIV_ : DIVU_;
      CAP_R:   div_op_next = op_is_signed(op_next) ? REM_ : REMU_;
      default: div_op_next = div_op_reg;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg         <= IDLE;
      counter_reg       <= '0;
      op_reg            <= DIV_;
      dividend_reg      <= '0;
      divisor_reg       <= '0;
      tag_reg           <= '0;
      q_capt_reg        <= '0;
      req_ready_reg     <= 1'b1;
      resp_valid_reg    <= 1'b0;
      resp_result_reg   <= '0;
      resp_tag_reg      <= '0;
      resp_zero_div_reg <= 1'b0;
      div_clk_en_reg    <= 1'b0;
      div_op_reg        <= DIV_;
      div_rst_n_reg     <= 1'b0;
    end else begin
      state_reg         <= state_next;
      counter_reg       <= counter_next;
      op_reg            <= op_next;
      dividend_reg      <= dividend_next;
      divisor_reg       <= divisor_next;
      tag_reg           <= tag_next;
      q_capt_reg        <= q_capt_next;
      req_ready_reg     <= req_ready_next;
      resp_valid_reg    <= resp_valid_next;
      resp_result_reg   <= resp_result_next;
      resp_tag_reg      <= resp_tag_next;
      resp_zero_div_reg <= resp_zero_div_next;
      div_clk_en_reg    <= div_clk_en_next;
      div_op_reg        <= div_op_next;
      div_rst_n_reg     <= !flush_i;
    end
  end

  assign bus.req_ready_o     = req_ready_reg;
  assign bus.resp_valid_o    = resp_valid_reg;
  assign bus.resp_result_o   = resp_result_reg;
  assign bus.resp_tag_o      = resp_tag_reg;
  assign bus.resp_zero_div_o = resp_zero_div_reg;
  assign fu_state_o          = (state_reg == IDLE) ? FREE : BUSY;
  assign div_dividend_o      = dividend_reg;
  assign div_divisor_o       = divisor_reg;
  assign div_op_o            = div_op_reg;
  assign div_clk_en_o        = div_clk_en_reg;
  assign div_rst_n_o         = div_rst_n_reg;

endmodule
